// File: rtl/mul_sequencer_if.sv
// Handshake and result bundle between the decode stage,
// the MUL sequencer and the write-back mux.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       dest_in;
  logic             busy;
  logic             stall;
  logic             done;
  logic             wb_en;
  logic [4:0]       wb_dest;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, flush, op_a, op_b, dest_in,
    input  busy, stall, done, wb_en,
    input  wb_dest, result_lo, result_hi
  );

  modport slave (
    input  start, flush, op_a, op_b, dest_in,
    output busy, stall, done, wb_en,
    output wb_dest, result_lo, result_hi
  );
endinterface

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier for the MUL path;
// stalls the pipeline while running, strobes write-back on completion.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          rst,
  mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         dest_q, dest_d;
  logic               accept;
  logic               run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    run      = (state_q == RUN);
    accept   = bus.start & ~bus.flush &
               ((state_q == IDLE) | (state_q == DONE));

    unique case (1'b1)
      accept: begin
        mcand_d  = {{WIDTH{1'b0}}, bus.op_a};
        mplier_d = bus.op_b;
        dest_d   = bus.dest_in;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = RUN;
      end
      run & ~bus.flush: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Counter parks at LAST; only a restart returns it to 0
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.wb_en     = (state_q == DONE);
  assign bus.stall     = (state_q == RUN) | accept;
  assign bus.wb_dest   = dest_q;
  assign bus.result_lo = acc_q[WIDTH-1:0];
  assign bus.result_hi = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: products are queued at
// launch and compared when the done strobe appears.
module tb_mul_sequencer;

  typedef struct {
    logic [4:0]  dest;
    logic [63:0] prod;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;
  exp_t sb[$];

  mul_sequencer_if #(.WIDTH(32)) bus ();

  mul_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      chk("wb_en", {63'd0, bus.wb_en}, 64'd1);
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_dest", {59'd0, bus.wb_dest}, {59'd0, e.dest});
        chk("product", {bus.result_hi, bus.result_lo}, e.prod);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input bit push);
    exp_t e;
    bus.start   = 1'b1;
    bus.op_a    = a;
    bus.op_b    = b;
    bus.dest_in = d;
    #1;
    chk("stall_on_start", {63'd0, bus.stall}, 64'd1);
    if (push) begin
      e.dest = d;
      e.prod = 64'(a) * 64'(b);
      sb.push_back(e);
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    int st;
    n  = 0;
    st = 1;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.stall === 1'b1) st++;
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd32);
    chk("stall_cycles", 64'(st), 64'd33);
    chk("stall_in_done", {63'd0, bus.stall}, 64'd0);
  endtask

  task automatic idle_window(input int cyc, input string tag);
    int d0;
    d0 = done_cnt;
    repeat (cyc) tick();
    chk(tag, 64'(done_cnt - d0), 64'd0);
  endtask

  initial begin
    int d0;
    checks      = 0;
    failures    = 0;
    done_cnt    = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.op_a    = '0;
    bus.op_b    = '0;
    bus.dest_in = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    chk("rst_dest", {59'd0, bus.wb_dest}, 64'd0);
    tick();

    // basic
    d0 = done_cnt;
    launch(32'd3, 32'd5, 5'd9, 1'b1);
    chk("busy_run", {63'd0, bus.busy}, 64'd1);
    wait_done();
    tick();
    chk("basic_one_done", 64'(done_cnt - d0), 64'd1);
    chk("idle_after_done", {63'd0, bus.busy}, 64'd0);

    // max and zero operands
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1);
    wait_done();
    tick();
    launch(32'd0, 32'h1234, 5'd2, 1'b1);
    wait_done();
    tick();

    // start ignored while busy
    d0 = done_cnt;
    launch(32'd3, 32'd5, 5'd9, 1'b1);
    repeat (9) tick();
    bus.start   = 1'b1;
    bus.op_a    = 32'd7;
    bus.dest_in = 5'd3;
    tick();
    bus.start = 1'b0;
    repeat (40) tick();
    chk("ignored_one_done", 64'(done_cnt - d0), 64'd1);

    // back-to-back
    launch(32'd2, 32'd3, 5'd1, 1'b1);
    wait_done();
    launch(32'd4, 32'd5, 5'd2, 1'b1);
    chk("b2b_no_gap", {63'd0, bus.busy}, 64'd1);
    wait_done();
    tick();

    // flush at RUN cycle 20
    launch(32'd9, 32'd9, 5'd4, 1'b0);
    repeat (19) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", {63'd0, bus.busy}, 64'd0);
    chk("flush_stall", {63'd0, bus.stall}, 64'd0);
    chk("flush_done", {63'd0, bus.done}, 64'd0);
    idle_window(40, "flush_no_done");
    launch(32'd6, 32'd7, 5'd5, 1'b1);
    wait_done();
    tick();

    // reset at RUN cycle 5
    launch(32'd11, 32'd13, 5'd6, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("mrst_done", {63'd0, bus.done}, 64'd0);
    chk("mrst_wb_en", {63'd0, bus.wb_en}, 64'd0);
    chk("mrst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    chk("mrst_dest", {59'd0, bus.wb_dest}, 64'd0);
    idle_window(40, "mrst_no_done");
    launch(32'd123456, 32'd654321, 5'd7, 1'b1);
    wait_done();
    tick();

    // a few random operands
    for (int i = 0; i < 4; i++) begin
      launch($urandom, $urandom, 5'($urandom_range(31, 0)), 1'b1);
      wait_done();
      tick();
    end

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
